// File: rtl/uart_ram_arbiter.sv
// Round-robin arbiter sharing one Wishbone RAM port between the CPU and a UART-RX byte writer.
// Received bytes go through a small FIFO and are written one byte per RAM cycle into a ring buffer.
// A local pointer/status register reports the write position and lets firmware flush the ring.
module uart_ram_arbiter #(
    parameter logic [31:0] ADR_LL     = 32'h00C00000,
    parameter logic [31:0] ADR_UL     = 32'h00C10000,
    parameter logic [31:0] PTR_ADR    = 32'h00C20000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [31:0] i_cpu_adr,
    input  logic [31:0] i_cpu_dat,
    input  logic [3:0]  i_cpu_sel,
    input  logic        i_cpu_we,
    input  logic        i_cpu_cyc,
    output logic [31:0] o_cpu_rdt,
    output logic        o_cpu_ack,
    input  logic [7:0]  i_rx_dat,
    input  logic        i_rx_valid,
    output logic        o_rx_overflow,
    output logic [31:0] o_ram_adr,
    output logic [31:0] o_ram_dat,
    output logic [3:0]  o_ram_sel,
    output logic        o_ram_we,
    output logic        o_ram_cyc,
    input  logic [31:0] i_ram_rdt,
    input  logic        i_ram_ack
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned IW = AW + 1;

    typedef enum logic [1:0] {IDLE, GNT_CPU, GNT_DMA, LOCAL} state_t;
    typedef enum logic {LG_CPU, LG_DMA} grant_t;

    state_t        state;
    grant_t        last_grant;
    logic [31:0]   wr_ptr;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;

    logic          fifo_empty;
    logic          fifo_full;
    logic [7:0]    fifo_head;
    logic          cpu_req;
    logic          cpu_local;
    logic          dma_req;
    logic          pop;
    logic          local_wr;
    logic          push;
    logic          drop;
    logic [31:0]   ptr_inc;
    logic [31:0]   ptr_next;

    // Request decode, FIFO status and ring pointer advance
    assign fifo_empty = (rd_idx == wr_idx);
    assign fifo_full  = (rd_idx[AW] != wr_idx[AW]) && (rd_idx[AW-1:0] == wr_idx[AW-1:0]);
    assign fifo_head  = fifo_mem[rd_idx[AW-1:0]];
    assign cpu_req    = i_cpu_cyc;
    assign cpu_local  = i_cpu_cyc && (i_cpu_adr == PTR_ADR);
    assign dma_req    = !fifo_empty;
    assign pop        = (state == GNT_DMA) && i_ram_ack;
    assign local_wr   = (state == LOCAL) && i_cpu_we;
    assign push       = i_rx_valid && (!fifo_full || pop) && !local_wr;
    assign drop       = i_rx_valid && fifo_full && !pop && !local_wr;
    assign ptr_inc    = wr_ptr + 32'd1;
    assign ptr_next   = (ptr_inc == ADR_UL) ? ADR_LL : ptr_inc;

    // CPU ack follows the RAM ack during a CPU grant; local register answers in one cycle
    assign o_cpu_ack = ((state == GNT_CPU) && i_ram_ack) || (state == LOCAL);

    // CPU read data mux: RAM data, local status word, or zero
    always_comb begin
        o_cpu_rdt = '0;
        if (state == GNT_CPU) begin
            o_cpu_rdt = i_ram_rdt;
        end else if (state == LOCAL) begin
            o_cpu_rdt = {o_rx_overflow, wr_ptr[30:0]};
        end
    end

    // FIFO storage, written at the push edge so i_rx_dat need not be held
    always_ff @(posedge i_wb_clk) begin
        if (push) begin
            fifo_mem[wr_idx[AW-1:0]] <= i_rx_dat;
        end
    end

    // Arbiter FSM, FIFO indices, ring pointer and registered RAM bus
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state         <= IDLE;
            last_grant    <= LG_DMA;
            wr_ptr        <= ADR_LL;
            rd_idx        <= '0;
            wr_idx        <= '0;
            o_rx_overflow <= 1'b0;
            o_ram_adr     <= '0;
            o_ram_dat     <= '0;
            o_ram_sel     <= '0;
            o_ram_we      <= 1'b0;
            o_ram_cyc     <= 1'b0;
        end else begin
            if (push) begin
                wr_idx <= wr_idx + IW'(1);
            end
            if (pop) begin
                rd_idx <= rd_idx + IW'(1);
            end
            if (drop) begin
                o_rx_overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (cpu_local) begin
                        state <= LOCAL;
                    end else if (cpu_req && (!dma_req || last_grant == LG_DMA)) begin
                        state     <= GNT_CPU;
                        o_ram_adr <= i_cpu_adr;
                        o_ram_dat <= i_cpu_dat;
                        o_ram_sel <= i_cpu_sel;
                        o_ram_we  <= i_cpu_we;
                        o_ram_cyc <= 1'b1;
                    end else if (dma_req) begin
                        state     <= GNT_DMA;
                        o_ram_adr <= {wr_ptr[31:2], 2'b00};
                        o_ram_dat <= {4{fifo_head}};
                        o_ram_sel <= 4'b0001 << wr_ptr[1:0];
                        o_ram_we  <= 1'b1;
                        o_ram_cyc <= 1'b1;
                    end
                end
                GNT_CPU: begin
                    if (i_ram_ack) begin
                        state      <= IDLE;
                        last_grant <= LG_CPU;
                        o_ram_adr  <= '0;
                        o_ram_dat  <= '0;
                        o_ram_sel  <= '0;
                        o_ram_we   <= 1'b0;
                        o_ram_cyc  <= 1'b0;
                    end
                end
                GNT_DMA: begin
                    if (i_ram_ack) begin
                        state      <= IDLE;
                        last_grant <= LG_DMA;
                        wr_ptr     <= ptr_next;
                        o_ram_adr  <= '0;
                        o_ram_dat  <= '0;
                        o_ram_sel  <= '0;
                        o_ram_we   <= 1'b0;
                        o_ram_cyc  <= 1'b0;
                    end
                end
                LOCAL: begin
                    state <= IDLE;
                    if (i_cpu_we) begin
                        wr_ptr        <= ADR_LL;
                        rd_idx        <= '0;
                        wr_idx        <= '0;
                        o_rx_overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ram_arbiter.sv
// Scoreboard bench for uart_ram_arbiter: expected RAM cycles and CPU acks are queued by
// the stimulus, and negedge monitors pop and compare whenever the DUT completes one.
module tb_uart_ram_arbiter;

    localparam logic [31:0] PTR = 32'h00C20000;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } ram_txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_adr, cpu_dat, cpu_rdt;
    logic [3:0]  cpu_sel;
    logic        cpu_we, cpu_cyc, cpu_ack;
    logic [7:0]  rx_dat;
    logic        rx_valid, rx_ovf;
    logic [31:0] ram_adr, ram_dat, ram_rdt;
    logic [3:0]  ram_sel;
    logic        ram_we, ram_cyc, ram_ack, ram_stall;

    logic [7:0]  w_rx_dat;
    logic        w_rx_valid, w_rx_ovf;
    logic [31:0] w_cpu_rdt, w_ram_adr, w_ram_dat;
    logic [3:0]  w_ram_sel;
    logic        w_cpu_ack, w_ram_we, w_ram_cyc, w_ram_ack;

    ram_txn_t    ram_q[$];
    ram_txn_t    w_q[$];
    logic [31:0] rdt_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    uart_ram_arbiter dut (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
        .i_cpu_cyc(cpu_cyc), .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
        .i_rx_dat(rx_dat), .i_rx_valid(rx_valid), .o_rx_overflow(rx_ovf),
        .o_ram_adr(ram_adr), .o_ram_dat(ram_dat), .o_ram_sel(ram_sel), .o_ram_we(ram_we),
        .o_ram_cyc(ram_cyc), .i_ram_rdt(ram_rdt), .i_ram_ack(ram_ack)
    );

    // Ring placed just below the default ADR_UL so the exact upper-limit wrap is reachable quickly
    uart_ram_arbiter #(.ADR_LL(32'h00C0FFFC)) dut_w (
        .i_wb_clk(clk), .i_wb_rst(rst),
        .i_cpu_adr(32'h0), .i_cpu_dat(32'h0), .i_cpu_sel(4'h0), .i_cpu_we(1'b0),
        .i_cpu_cyc(1'b0), .o_cpu_rdt(w_cpu_rdt), .o_cpu_ack(w_cpu_ack),
        .i_rx_dat(w_rx_dat), .i_rx_valid(w_rx_valid), .o_rx_overflow(w_rx_ovf),
        .o_ram_adr(w_ram_adr), .o_ram_dat(w_ram_dat), .o_ram_sel(w_ram_sel), .o_ram_we(w_ram_we),
        .o_ram_cyc(w_ram_cyc), .i_ram_rdt(32'h0), .i_ram_ack(w_ram_ack)
    );

    // servant_ram-style models: ack one cycle after cyc, read data tagged with the address
    always @(posedge clk) begin
        if (rst) begin
            ram_ack   <= 1'b0;
            w_ram_ack <= 1'b0;
        end else begin
            ram_ack   <= ram_cyc && !ram_ack && !ram_stall;
            w_ram_ack <= w_ram_cyc && !w_ram_ack;
        end
        ram_rdt <= 32'hCAFE0000 | {16'h0, ram_adr[15:0]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_txn(input string tag, input ram_txn_t e, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input logic we);
        chk({tag, "_adr"}, adr, e.adr);
        chk({tag, "_sel"}, 32'(sel), 32'(e.sel));
        chk({tag, "_we"}, 32'(we), 32'(e.we));
        if (e.we) chk({tag, "_dat"}, dat, e.dat);
    endtask

    // Main monitor: RAM cycle completions, CPU acks, and the idle gap after each grant
    logic prev_done;
    always @(negedge clk) begin
        ram_txn_t e;
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("idle_gap", 32'(ram_cyc), 32'd0);
            prev_done = ram_cyc && ram_ack;
            if (ram_cyc && ram_ack) begin
                if (ram_q.size() == 0) begin
                    chk("unexpected_ram_cycle_adr", ram_adr, 32'hFFFFFFFF);
                end else begin
                    e = ram_q.pop_front();
                    cmp_txn("ram", e, ram_adr, ram_dat, ram_sel, ram_we);
                end
            end
            if (cpu_ack) begin
                if (rdt_q.size() == 0) chk("unexpected_cpu_ack", 32'(cpu_ack), 32'd0);
                else chk("cpu_rdt", cpu_rdt, rdt_q.pop_front());
            end
        end
    end

    // Wrap-instance monitor
    always @(negedge clk) begin
        ram_txn_t e;
        if (!rst) begin
            if (w_cpu_ack) chk("w_unexpected_cpu_ack", 32'(w_cpu_ack), 32'd0);
            if (w_ram_cyc && w_ram_ack) begin
                if (w_q.size() == 0) begin
                    chk("w_unexpected_ram_cycle_adr", w_ram_adr, 32'hFFFFFFFF);
                end else begin
                    e = w_q.pop_front();
                    cmp_txn("wrap", e, w_ram_adr, w_ram_dat, w_ram_sel, w_ram_we);
                end
            end
        end
    end

    task automatic exp_ram(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we);
        ram_txn_t t;
        t.adr = adr; t.dat = dat; t.sel = sel; t.we = we;
        ram_q.push_back(t);
    endtask

    task automatic exp_w(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        ram_txn_t t;
        t.adr = adr; t.dat = dat; t.sel = sel; t.we = 1'b1;
        w_q.push_back(t);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        rx_dat = d;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic w_rx_byte(input logic [7:0] d);
        w_rx_dat = d;
        w_rx_valid = 1'b1;
        @(posedge clk); #1;
        w_rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // One CPU access; returns one cycle after the ack edge with cyc dropped
    task automatic cpu_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [31:0] exp_rdt, input bit push_ram);
        int n;
        if (push_ram) exp_ram(adr, dat, 4'hF, we);
        rdt_q.push_back(exp_rdt);
        cpu_adr = adr; cpu_we = we; cpu_dat = dat; cpu_sel = 4'hF; cpu_cyc = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ack && n < 300);
        if (!cpu_ack) chk("cpu_ack_timeout", 32'(cpu_ack), 32'd1);
        @(posedge clk); #1;
        cpu_cyc = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((ram_q.size() != 0 || w_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(ram_q.size() + w_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; ram_stall = 1'b0;
        cpu_adr = '0; cpu_dat = '0; cpu_sel = '0; cpu_we = 1'b0; cpu_cyc = 1'b0;
        rx_dat = '0; rx_valid = 1'b0; w_rx_dat = '0; w_rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_cyc", 32'(ram_cyc), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_overflow", 32'(rx_ovf), 32'd0);
        chk("rst_cpu_rdt", cpu_rdt, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Three bytes into an idle arbiter, then pointer readback
        exp_ram(32'h00C00000, 32'h41414141, 4'b0001, 1'b1);
        exp_ram(32'h00C00000, 32'h42424242, 4'b0010, 1'b1);
        exp_ram(32'h00C00000, 32'h43434343, 4'b0100, 1'b1);
        rx_byte(8'h41); rx_byte(8'h42); rx_byte(8'h43);
        wait_drain();
        cpu_txn(PTR, 1'b0, 32'h0, 32'h00C00003, 1'b0);

        // CPU read latency with an empty FIFO
        exp_ram(32'h00000010, 32'h0, 4'hF, 1'b0);
        rdt_q.push_back(32'hCAFE0010);
        cpu_adr = 32'h00000010; cpu_we = 1'b0; cpu_dat = '0; cpu_sel = 4'hF; cpu_cyc = 1'b1;
        @(negedge clk); chk("lat_c1_ram_cyc", 32'(ram_cyc), 32'd0);
        @(negedge clk); chk("lat_c2_ram_cyc", 32'(ram_cyc), 32'd1);
        chk("lat_c2_cpu_ack", 32'(cpu_ack), 32'd0);
        @(negedge clk); chk("lat_c3_cpu_ack", 32'(cpu_ack), 32'd1);
        @(posedge clk); #1;
        cpu_cyc = 1'b0;
        @(negedge clk); chk("lat_single_ack", 32'(cpu_ack), 32'd0);
        @(posedge clk); #1;

        // CPU held busy while four bytes arrive: grants must alternate
        exp_ram(32'h00000020, 32'h0, 4'hF, 1'b0);
        exp_ram(32'h00C00000, 32'h51515151, 4'b1000, 1'b1);
        exp_ram(32'h00000020, 32'h0, 4'hF, 1'b0);
        exp_ram(32'h00C00004, 32'h52525252, 4'b0001, 1'b1);
        exp_ram(32'h00000020, 32'h0, 4'hF, 1'b0);
        exp_ram(32'h00C00004, 32'h53535353, 4'b0010, 1'b1);
        exp_ram(32'h00000020, 32'h0, 4'hF, 1'b0);
        exp_ram(32'h00C00004, 32'h54545454, 4'b0100, 1'b1);
        exp_ram(32'h00000020, 32'h0, 4'hF, 1'b0);
        fork
            for (int i = 0; i < 5; i++) cpu_txn(32'h00000020, 1'b0, 32'h0, 32'hCAFE0020, 1'b0);
            for (int j = 0; j < 4; j++) rx_byte(8'h51 + 8'(j));
        join
        wait_drain();

        // Stalled CPU grant blocks the FIFO: fifth byte overflows
        ram_stall = 1'b1;
        fork
            cpu_txn(32'h00000030, 1'b0, 32'h0, 32'hCAFE0030, 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                for (int k = 0; k < 4; k++) rx_byte(8'h61 + 8'(k));
                @(negedge clk); chk("full_no_overflow", 32'(rx_ovf), 32'd0);
                rx_byte(8'h65);
                @(negedge clk); chk("overflow_set", 32'(rx_ovf), 32'd1);
                chk("stalled_no_ack", 32'(cpu_ack), 32'd0);
                ram_stall = 1'b0;
            end
        join
        cpu_txn(PTR, 1'b0, 32'h0, 32'h80C00007, 1'b0);
        cpu_txn(PTR, 1'b1, 32'h12345678, 32'h80C00007, 1'b0);
        cpu_txn(PTR, 1'b0, 32'h0, 32'h00C00000, 1'b0);
        @(negedge clk); chk("overflow_cleared", 32'(rx_ovf), 32'd0);
        @(posedge clk); #1;
        exp_ram(32'h00C00000, 32'h71717171, 4'b0001, 1'b1);
        rx_byte(8'h71);
        wait_drain();

        // Ring wrap at the exact upper limit (second instance)
        exp_w(32'h00C0FFFC, 32'h91919191, 4'b0001);
        exp_w(32'h00C0FFFC, 32'h92929292, 4'b0010);
        exp_w(32'h00C0FFFC, 32'h93939393, 4'b0100);
        exp_w(32'h00C0FFFC, 32'h94949494, 4'b1000);
        exp_w(32'h00C0FFFC, 32'h95959595, 4'b0001);
        for (int m = 0; m < 5; m++) w_rx_byte(8'h91 + 8'(m));
        wait_drain();

        // Reset during a DMA grant abandons the cycle and the byte
        rx_byte(8'h81);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ram_cyc && ram_we) && n < 20);
        chk("dma_grant_seen", 32'(ram_cyc && ram_we), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ram_cyc", 32'(ram_cyc), 32'd0);
        chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
        chk("mid_rst_cpu_ack", 32'(cpu_ack), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_no_dma", 32'(ram_cyc), 32'd0);
        @(posedge clk); #1;
        cpu_txn(PTR, 1'b0, 32'h0, 32'h00C00000, 1'b0);
        chk("ack_queue_empty", 32'(rdt_q.size()), 32'd0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_ram_arbiter.md
Name: uart_ram_arbiter

Overview:
- Shares the single-port servant_ram Wishbone slave between the servant CPU data/instruction bus and a UART-RX byte writer.
- Received BLE bytes are buffered in a small FIFO, then written one byte per RAM cycle into a circular region [ADR_LL, ADR_UL).
- Arbitration is round-robin. Only complete, non-overlapping RAM cycles are issued.
- A local pointer register lets firmware read the current write position and flush the buffer.

Parameters:
- ADR_LL, 32'h00C00000, ring base, byte address, inclusive.
- ADR_UL, 32'h00C10000, ring limit, byte address, exclusive. ADR_UL > ADR_LL.
- PTR_ADR, 32'h00C20000, CPU address of the local pointer/status register.
- FIFO_DEPTH, 4, RX byte FIFO entries. Power of two, ≥2.

Ports:
- i_wb_clk  in  1  system clock
- i_wb_rst  in  1  synchronous active-high reset
- i_cpu_adr  in  32  CPU byte address
- i_cpu_dat  in  32  CPU write data
- i_cpu_sel  in  4  CPU byte enables
- i_cpu_we  in  1  CPU write strobe
- i_cpu_cyc  in  1  CPU cycle request, held until o_cpu_ack
- o_cpu_rdt  out  32  CPU read data
- o_cpu_ack  out  1  CPU acknowledge, 1-cycle pulse
- i_rx_dat  in  8  received byte
- i_rx_valid  in  1  1-cycle strobe, i_rx_dat valid
- o_rx_overflow  out  1  sticky: a byte was dropped
- o_ram_adr  out  32  RAM address
- o_ram_dat  out  32  RAM write data
- o_ram_sel  out  4  RAM byte enables
- o_ram_we  out  1  RAM write
- o_ram_cyc  out  1  RAM cycle
- i_ram_rdt  in  32  RAM read data
- i_ram_ack  in  1  RAM acknowledge (servant_ram: one cycle after cyc)

Behaviour:
- Clock/reset: one clock, i_wb_clk. Reset is synchronous and active-high (i_wb_rst); polarity and synchronicity are fixed.
- Reset values: state=IDLE; o_ram_cyc=0; o_ram_we=0; o_cpu_ack=0; FIFO empty; wr_ptr=ADR_LL; o_rx_overflow=0; last_grant=DMA, so the CPU wins the first tie.
- Reset mid-cycle: the cycle is abandoned. No ack is issued. The FIFO byte is discarded.
- FSM states: IDLE, GNT_CPU, GNT_DMA, LOCAL.
- Requests:
  - cpu_req = i_cpu_cyc.
  - cpu_local = i_cpu_cyc && i_cpu_adr==PTR_ADR.
  - dma_req = FIFO not empty.
- IDLE transitions:
  - cpu_local → LOCAL. Takes precedence; no RAM involvement.
  - Both cpu_req (non-local) and dma_req → grant the one not equal to last_grant.
  - Only one request → grant it.
  - No request → stay in IDLE.
- GNT_CPU:
  - o_ram_* = i_cpu_*. o_ram_cyc=1.
  - o_cpu_ack = i_ram_ack (combinational). o_cpu_rdt = i_ram_rdt.
  - On i_ram_ack: last_grant=CPU, go to IDLE.
- GNT_DMA:
  - o_ram_adr = {wr_ptr[31:2],2'b00}.
  - o_ram_sel = 4'b0001 << wr_ptr[1:0].
  - o_ram_dat = FIFO head replicated to all 4 lanes.
  - o_ram_we=1, o_ram_cyc=1.
  - On i_ram_ack: pop FIFO; wr_ptr = (wr_ptr+1 == ADR_UL) ? ADR_LL : wr_ptr+1; last_grant=DMA; go to IDLE.
- IDLE and LOCAL: o_ram_cyc=0, o_ram_we=0, all other o_ram_* = 0.
- Mandatory IDLE cycle after every grant: guarantees o_ram_cyc drops, so servant_ram's toggling ack never double-acks.
- Latency: a CPU RAM access with the arbiter free takes 3 cycles from i_cpu_cyc to o_cpu_ack (IDLE decision, cyc, ack).
- LOCAL register access:
  - o_cpu_ack=1 for exactly one cycle, then IDLE.
  - Read: o_cpu_rdt = {o_rx_overflow, wr_ptr[30:0]}.
  - Write (i_cpu_we=1): wr_ptr=ADR_LL, FIFO flushed, o_rx_overflow=0. Takes effect at the ack edge. A coincident i_rx_valid byte is discarded.
- o_cpu_rdt outside GNT_CPU/LOCAL: 0. o_cpu_ack is never asserted in IDLE/GNT_DMA.
- FIFO push rules:
  - Push on i_rx_valid.
  - If full and no pop in the same cycle: byte dropped, o_rx_overflow=1 (sticky).
  - Full with simultaneous pop: push accepted, no overflow.
  - Empty with push: the byte is poppable no earlier than the next IDLE decision.
- Write data goes into the FIFO at the push edge. i_rx_dat need not be held.
- Pointer arithmetic: 32-bit unsigned. Compare against ADR_UL exactly. No clamping beyond wrap.

Test Plan:
- Reset, then 3 RX bytes 0x41,0x42,0x43, CPU idle → 3 DMA writes to 0x00C00000 with sel 0001/0010/0100, dat 0x41414141 / 0x42424242 / 0x43434343. Pointer read returns 0x00C00003.
- CPU read of 0x00000010 while FIFO empty → o_ram_cyc on cycle 2, o_cpu_ack on cycle 3, o_cpu_rdt=RAM word. Exactly one ack.
- CPU read held continuously while 4 RX bytes arrive → grants alternate CPU, DMA, CPU, DMA…, separated by one IDLE cycle each. No request starves.
- wr_ptr preset by 65535 bytes to 0x00C0FFFF, then 2 bytes → writes at 0x00C0FFFF (sel 1000), then 0x00C00000 (sel 0001).
- CPU stalls FIFO (held CPU grant), 5 bytes with FIFO_DEPTH=4 → 5th dropped, o_rx_overflow=1, pointer read bit31=1. CPU write to PTR_ADR → overflow 0, pointer 0x00C00000, FIFO empty.
- Assert i_wb_rst during GNT_DMA → next cycle o_ram_cyc=0, state IDLE, pointer ADR_LL, no CPU ack.
